// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
//   state_t            loader FSM states
//   LEN_WIDTH_DEFAULT  width of the word-count header
//   BYTES_PER_WORD     bytes packed into one instruction word
//   BYTE_CNT_WIDTH     width of the byte-within-word counter
package prog_loader_pkg;

    localparam int unsigned LEN_WIDTH_DEFAULT = 16;
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned BYTE_CNT_WIDTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   in_valid/in_data/in_ready  byte stream from the external source (valid/ready)
//   im_we/im_addr/im_wd        instruction-memory write port (one pulse per word)
// Modports: master = byte source / memory side, slave = loader.
interface prog_loader_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     im_we;
    logic [ADDRESS_WIDTH-1:0] im_addr;
    logic [DATA_WIDTH-1:0]    im_wd;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wd
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wd
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
//   i_clk, i_rst   clock, async active-high reset
//   i_clear        drop any partial word (new load)
//   i_valid        i_byte is accepted this cycle
//   i_byte         byte to pack
//   o_byte_cnt     bytes already held for the current word
//   o_word_valid   one-cycle pulse the cycle after the 4th byte
//   o_word         last completed word (first byte in [7:0]), held between pulses
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic [7:0]                i_byte,
    output logic [BYTE_CNT_WIDTH-1:0] o_byte_cnt,
    output logic                      o_word_valid,
    output logic [31:0]               o_word
);

    logic [BYTE_CNT_WIDTH-1:0] r_cnt;
    logic [23:0]               r_shift;
    logic [31:0]               r_word;
    logic                      r_word_valid;

    // New bytes enter at the top so the first byte ends up in the low lane.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
                r_word  <= '0;
            end else if (i_valid) begin
                r_cnt   <= r_cnt + BYTE_CNT_WIDTH'(1);
                r_shift <= {i_byte, r_shift[23:8]};
                if (r_cnt == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1)) begin
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_byte_cnt   = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the payload
// into instruction memory as 32-bit words and holds the core in reset meanwhile.
//   i_clk, i_rst  clock, async active-high reset
//   i_start       pulse: begin a new load (honoured in IDLE/DONE/ERR only)
//   bus           prog_loader_if.slave: byte stream in, instr-memory write port out
//   o_cpu_hold    core reset, 1 = held
//   o_busy        load in progress
//   o_done        last load completed
//   o_error       last load failed its checksum
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the payload; without it o_error is tied low.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LEN_WIDTH     = LEN_WIDTH_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    prog_loader_if.slave bus,
    output logic         o_cpu_hold,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error
);

    state_t                    r_state;
    logic                      r_in_ready;
    logic                      r_cpu_hold;
    logic                      r_busy;
    logic                      r_done;
    logic [7:0]                r_len_lo;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [LEN_WIDTH-1:0]      r_word_idx;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
`ifdef LOADER_CHECKSUM_EN
    logic                      r_error;
    logic [7:0]                r_csum;
`endif

    logic                      w_accept;
    logic                      w_data_accept;
    logic                      w_start_ok;
    logic                      w_last_byte;
    logic [LEN_WIDTH-1:0]      w_len_hdr;
    logic [BYTE_CNT_WIDTH-1:0] w_byte_cnt;
    logic                      w_word_valid;
    logic [31:0]               w_word;

    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_data_accept = w_accept && (r_state == ST_DATA);
    assign w_start_ok    = i_start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign w_len_hdr     = LEN_WIDTH'({bus.in_data, r_len_lo});

    // Word counter only advances on the write pulse, which always lands before the
    // next word's 4th byte, so it still names the word being packed here.
    assign w_last_byte = w_data_accept
                      && (w_byte_cnt == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1))
                      && (r_word_idx == r_len - LEN_WIDTH'(1));

    prog_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start_ok),
        .i_valid      (w_data_accept),
        .i_byte       (bus.in_data),
        .o_byte_cnt   (w_byte_cnt),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Loader FSM with its address/word counters and checksum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_error    <= 1'b0;
            r_csum     <= '0;
`endif
        end else begin
            // Address follows the write pulse; wraps naturally at 2^ADDRESS_WIDTH.
            if (w_word_valid) begin
                r_word_idx <= r_word_idx + LEN_WIDTH'(1);
                r_addr     <= r_addr + ADDRESS_WIDTH'(BYTES_PER_WORD);
            end
`ifdef LOADER_CHECKSUM_EN
            if (w_data_accept) begin
                r_csum <= r_csum ^ bus.in_data;
            end
`endif
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_state    <= ST_LEN_LO;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_word_idx <= '0;
                        r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_error    <= 1'b0;
                        r_csum     <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= bus.in_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_hdr;
                        if (w_len_hdr == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    // Final write pulse overlaps the first CSUM cycle.
                    if (w_last_byte) begin
                        r_state <= ST_CSUM;
                    end
`else
                    // Stop accepting after the last byte, finish once its word is written.
                    if (w_last_byte) begin
                        r_in_ready <= 1'b0;
                    end else if (!r_in_ready && w_word_valid) begin
                        r_state    <= ST_DONE;
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
`endif
                end
                ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state    <= ST_DONE;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.im_we    = w_word_valid;
    assign bus.im_addr  = r_addr;
    assign bus.im_wd    = DATA_WIDTH'(w_word);
    assign o_cpu_hold   = r_cpu_hold;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign o_error      = r_error;
`else
    assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: reset values, table-driven loads,
// the reference sequences, async reset, random loads, address wrap and abort.
module tb_prog_loader;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_hold, busy, done, error;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    prog_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .bus        (bus),
        .o_cpu_hold (cpu_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  payload[$];
    logic [7:0]  got_addr[$];
    logic [31:0] got_wd[$];

    typedef struct {
        int unsigned len;
        bit          gaps;
        bit          bad;
        bit          exp_done;
        bit          exp_error;
        bit          exp_hold;
    } vec_t;

    vec_t tbl[6];

    // Record every write pulse seen on the memory port.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            got_addr.push_back(bus.im_addr);
            got_wd.push_back(bus.im_wd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte, holding it until the loader accepts it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic fill_payload(input int unsigned len);
        payload.delete();
        for (int i = 0; i < int'(len) * 4; i++) payload.push_back(8'($urandom));
    endtask

    // Send a whole load and compare against the expected writes and final status.
    task automatic run_load(input string tag, input int unsigned len, input bit gaps, input bit bad);
        logic [7:0]  csum;
        logic [31:0] exp_wd;
        bit          exp_err;
        int          n;
        csum = 8'h00;
        foreach (payload[i]) csum = csum ^ payload[i];
        got_addr.delete();
        got_wd.delete();
        do_start();
        send_byte(8'(len), gaps);
        send_byte(8'(len >> 8), gaps);
        foreach (payload[i]) send_byte(payload[i], gaps);
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad ? (csum ^ 8'h01) : csum, gaps);
        exp_err = bad;
`else
        exp_err = 1'b0;
`endif
        bus.in_valid = 1'b0;
        n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished"}, 32'(n < 20), 32'd1);
        chk({tag, " done"}, 32'(done), 32'(!exp_err));
        chk({tag, " error"}, 32'(error), 32'(exp_err));
        chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, " writes"}, 32'(got_wd.size()), 32'(len));
        for (int i = 0; i < int'(len) && i < got_wd.size(); i++) begin
            exp_wd = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
            chk($sformatf("%s addr[%0d]", tag, i), 32'(got_addr[i]), 32'((4 * i) % 256));
            chk($sformatf("%s wd[%0d]", tag, i), got_wd[i], exp_wd);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        start        = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst im_we", 32'(bus.im_we), 32'd0);
        chk("rst im_addr", 32'(bus.im_addr), 32'd0);
        chk("rst im_wd", bus.im_wd, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst error", 32'(error), 32'd0);

        // Table-driven loads
        tbl[0] = '{len: 2, gaps: 1'b0, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        tbl[1] = '{len: 2, gaps: 1'b1, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        tbl[2] = '{len: 0, gaps: 1'b0, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        tbl[3] = '{len: 1, gaps: 1'b1, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
`ifdef LOADER_CHECKSUM_EN
        tbl[4] = '{len: 3, gaps: 1'b0, bad: 1'b1, exp_done: 1'b0, exp_error: 1'b1, exp_hold: 1'b1};
`else
        tbl[4] = '{len: 3, gaps: 1'b0, bad: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
`endif
        tbl[5] = '{len: 4, gaps: 1'b1, bad: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_hold: 1'b0};
        for (int t = 0; t < 6; t++) begin
            fill_payload(tbl[t].len);
            run_load($sformatf("tbl%0d", t), tbl[t].len, tbl[t].gaps, tbl[t].bad);
            chk($sformatf("tbl%0d done_col", t), 32'(done), 32'(tbl[t].exp_done));
            chk($sformatf("tbl%0d error_col", t), 32'(error), 32'(tbl[t].exp_error));
            chk($sformatf("tbl%0d hold_col", t), 32'(cpu_hold), 32'(tbl[t].exp_hold));
        end

        // Reference program, back-to-back then with in_valid toggling
        for (int g = 0; g < 2; g++) begin
            payload = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
            run_load($sformatf("ref%0d", g), 2, g[0], 1'b0);
            if (got_wd.size() == 2) begin
                chk($sformatf("ref%0d word0", g), got_wd[0], 32'h00A00513);
                chk($sformatf("ref%0d word1", g), got_wd[1], 32'h0000006F);
                chk($sformatf("ref%0d addr1", g), 32'(got_addr[1]), 32'd4);
            end
        end

        // Async reset mid-cycle after a completed load
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst cpu_hold", 32'(cpu_hold), 32'd1);
        chk("arst done", 32'(done), 32'd0);
        chk("arst in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst im_we", 32'(bus.im_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        // Explicit checksum pair: 11^22^33^44 = 44
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("csum_ok", 1, 1'b0, 1'b0);
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load("csum_bad", 1, 1'b0, 1'b1);
`endif

        // Random loads
        for (int r = 0; r < 12; r++) begin
            int unsigned len;
            len = $urandom_range(0, 5);
            fill_payload(len);
            run_load($sformatf("rnd%0d", r), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // 65 words: the last one wraps to address 0
        fill_payload(65);
        run_load("wrap", 65, 1'b0, 1'b0);
        if (got_addr.size() == 65) chk("wrap addr64", 32'(got_addr[64]), 32'd0);

        // Abort with reset after header + one word
        fill_payload(2);
        got_addr.delete();
        got_wd.delete();
        do_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(payload[i], 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort cpu_hold", 32'(cpu_hold), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 4; i < 8; i++) begin
            bus.in_data = payload[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort writes", 32'(got_wd.size()), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        chk("abort busy_after", 32'(busy), 32'd0);
        if (got_wd.size() >= 1)
            chk("abort word0", got_wd[0], {payload[3], payload[2], payload[1], payload[0]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
